// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl
//   Data-memory access controller between the core's dmem port and a
//   synchronous single-port SRAM with byte write enables. One request is
//   latched, the SRAM is strobed once, WAIT_CYCLES wait states follow, and a
//   single-cycle acknowledge closes the transaction. Stores are lane-steered
//   with matching byte enables; misaligned or reserved-scope requests are
//   rejected without touching the SRAM but still take the full latency.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no request in flight; sample en_i and latch the request
//   STROBE | drive the SRAM strobe (suppressed when rejected), load cnt
//   WAIT   | count down wait states; capture load data when cnt hits 0
//   ACK    | one-cycle rdata_valid_o (+ misalign_o when rejected)
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   en_i              core request, held stable until acknowledged
//   wr_i              1 = store, 0 = load
//   addr_i            byte address
//   wdata_i           store data, right-aligned
//   wscope_i          access size: 00 byte, 01 half, 10 word, 11 reserved
//   rdata_o           last accepted load word (registered)
//   rdata_valid_o     one-cycle acknowledge for loads and stores
//   misalign_o        one-cycle reject flag, coincident with the acknowledge
//   mem_en_o          SRAM strobe, one cycle per accepted request
//   mem_we_o          SRAM byte write enables
//   mem_addr_o        SRAM word address
//   mem_wdata_o       lane-steered SRAM write data
//   mem_rdata_i       SRAM read data, valid the cycle after a read strobe

module dmem_wait_ctrl #(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [1:0]    wscope_i,
  output logic [31:0]   rdata_o,
  output logic          rdata_valid_o,
  output logic          misalign_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  localparam logic [1:0] SC_BYTE = 2'b00;
  localparam logic [1:0] SC_HALF = 2'b01;
  localparam logic [1:0] SC_WORD = 2'b10;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  // Only the bits that reach the SRAM or select lanes are kept.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW+2];

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [AW+1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [1:0]     scope_q, scope_d;
  logic           rej_q, rej_d;
  logic [31:0]    rdata_q, rdata_d;

  logic [3:0]     lane_we;
  logic [31:0]    lane_wdata;

  // Alignment rule applies to loads and stores alike.
  function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] sc);
    logic r;
    case (sc)
      SC_BYTE: r = 1'b0;
      SC_HALF: r = a[0];
      SC_WORD: r = (a != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Store lane steering from the latched request.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = 32'h0;
    case (scope_q)
      SC_BYTE: begin
        lane_wdata = {4{wdata_q[7:0]}};
        lane_we    = 4'b0001 << addr_q[1:0];
      end
      SC_HALF: begin
        lane_wdata = {2{wdata_q[15:0]}};
        lane_we    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      SC_WORD: begin
        lane_wdata = wdata_q;
        lane_we    = 4'b1111;
      end
      default: begin
        lane_wdata = 32'h0;
        lane_we    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      scope_q <= 2'b00;
      rej_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      scope_q <= scope_d;
      rej_q   <= rej_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode state and latched registers only, so en_i never has a
  // combinational path to any output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    scope_d       = scope_q;
    rej_d         = rej_q;
    rdata_d       = rdata_q;
    rdata_valid_o = 1'b0;
    misalign_o    = 1'b0;
    mem_en_o      = 1'b0;
    mem_we_o      = 4'b0000;
    mem_addr_o    = '0;
    mem_wdata_o   = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          wr_d    = wr_i;
          addr_d  = addr_i[AW+1:0];
          wdata_d = wdata_i;
          scope_d = wscope_i;
          rej_d   = is_misaligned(addr_i[1:0], wscope_i);
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (!rej_q) begin
          mem_en_o   = 1'b1;
          mem_addr_o = addr_q[AW+1:2];
          if (wr_q) begin
            mem_we_o    = lane_we;
            mem_wdata_o = lane_wdata;
          end
        end
        cnt_d   = WAIT_LD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // SRAM holds its read data until the next access, so capturing
          // after any number of wait states is safe.
          if (!wr_q && !rej_q) begin
            rdata_d = mem_rdata_i;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        rdata_valid_o = 1'b1;
        misalign_o    = rej_q;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata_o = rdata_q;

endmodule
